// File: rtl/coin_encoder.sv
// coin_encoder: debounces two coin sensors and emits a one-cycle coin code
// for the downstream vending-machine FSM.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no coin seen, waiting for exactly one sensor to go high
// QUAL    | one sensor high alone, counting consecutive high samples
// EMIT    | coin qualified, code driven for this single cycle
// RELEASE | coin accepted, waiting for both sensors low
// REJECT  | both sensors seen high, waiting for both sensors low
module coin_encoder #(
  parameter int DEB = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_5,
  input  logic       coin_10,
  output logic [1:0] code,
  output logic       reject,
  output logic [7:0] coin_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUAL    = 3'd1,
    EMIT    = 3'd2,
    RELEASE = 3'd3,
    REJECT  = 3'd4
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(DEB - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       sel;
  logic       sel_hi;
  logic       oth_hi;

  // Selected and non-selected sensor levels as seen from the current coin.
  assign sel_hi = sel ? coin_10 : coin_5;
  assign oth_hi = sel ? coin_5  : coin_10;

  // Coin qualification FSM with registered code, reject and coin count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      sel      <= 1'b0;
      code     <= 2'b11;
      reject   <= 1'b0;
      coin_cnt <= 8'd0;
    end else begin
      code   <= 2'b11;
      reject <= 1'b0;
      case (state)
        IDLE: begin
          if (coin_5 && coin_10) begin
            state  <= REJECT;
            reject <= 1'b1;
          end else if (coin_5 ^ coin_10) begin
            state <= QUAL;
            cnt   <= 4'd1;
            sel   <= coin_10;
          end
        end
        QUAL: begin
          if (coin_5 && coin_10) begin
            state  <= REJECT;
            reject <= 1'b1;
          end else if (sel_hi && !oth_hi) begin
            if (cnt == CNT_LAST) begin
              state <= EMIT;
              code  <= {1'b0, sel};
              if (coin_cnt != 8'hFF) coin_cnt <= coin_cnt + 8'd1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else begin
            // Selected sensor dropped: glitch, or the other coin must requalify.
            state <= IDLE;
          end
        end
        EMIT: begin
          state <= RELEASE;
        end
        RELEASE: begin
          if (!coin_5 && !coin_10) state <= IDLE;
        end
        REJECT: begin
          if (!coin_5 && !coin_10) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_encoder.sv
// Testbench for coin_encoder: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_coin_encoder;

  localparam int DEB = 4;

  logic       clk;
  logic       rst;
  logic       coin_5;
  logic       coin_10;
  logic [1:0] code;
  logic       reject;
  logic [7:0] coin_cnt;

  int errors = 0;
  int checks = 0;

  int n_c00 = 0;
  int n_c01 = 0;
  int n_rej = 0;

  coin_encoder #(.DEB(DEB)) dut (
    .clk     (clk),
    .rst     (rst),
    .coin_5  (coin_5),
    .coin_10 (coin_10),
    .code    (code),
    .reject  (reject),
    .coin_cnt(coin_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a coin is accepted after DEB consecutive samples of one
  // sensor alone; after any accept/reject the slot is locked until both
  // sensors read low (the accept cycle itself is never an unlock sample).
  logic [1:0] m_code;
  logic       m_rej;
  logic [7:0] m_cnt;
  int         run;
  logic       who;
  logic       locked;
  logic       skip;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_code = 2'b11; m_rej = 1'b0; m_cnt = 8'd0;
      run = 0; who = 1'b0; locked = 1'b0; skip = 1'b0;
    end else begin
      m_code = 2'b11;
      m_rej  = 1'b0;
      if (skip) begin
        skip = 1'b0;
      end else if (locked) begin
        if (!coin_5 && !coin_10) locked = 1'b0;
      end else if (coin_5 && coin_10) begin
        m_rej = 1'b1; locked = 1'b1; run = 0;
      end else if (coin_5 || coin_10) begin
        if (run > 0 && who != coin_10) begin
          run = 0;
        end else begin
          if (run == 0) who = coin_10;
          run++;
          if (run == DEB) begin
            m_code = {1'b0, who};
            if (m_cnt != 8'hFF) m_cnt++;
            locked = 1'b1; skip = 1'b1; run = 0;
          end
        end
      end else begin
        run = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("code", 32'(code), 32'(m_code));
    chk("reject", 32'(reject), 32'(m_rej));
    chk("coin_cnt", 32'(coin_cnt), 32'(m_cnt));
    if (code == 2'b00) n_c00++;
    if (code == 2'b01) n_c01++;
    if (reject) n_rej++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic c5, input logic c10, input int n);
    coin_5 = c5;
    coin_10 = c10;
    step(n);
  endtask

  int b00, b01, brej;

  initial begin
    rst = 1'b0; coin_5 = 1'b0; coin_10 = 1'b0;
    step(3);
    chk("rst_code", 32'(code), 32'h3);
    chk("rst_reject", 32'(reject), 32'h0);
    chk("rst_cnt", 32'(coin_cnt), 32'h0);
    rst = 1'b1;
    step(2);

    // coin_5 held 10 edges: single 00 pulse after the 4th edge
    b00 = n_c00; brej = n_rej;
    coin_5 = 1'b1;
    step(3);
    chk("c5_before_deb", 32'(code), 32'h3);
    step(1);
    chk("c5_at_deb", 32'(code), 32'h0);
    step(1);
    chk("c5_after_deb", 32'(code), 32'h3);
    step(5);
    drive(1'b0, 1'b0, 3);
    chk("c5_pulses", 32'(n_c00 - b00), 32'd1);
    chk("c5_cnt", 32'(coin_cnt), 32'd1);
    chk("c5_no_reject", 32'(n_rej - brej), 32'd0);

    // coin_10 glitch of 2 edges: filtered
    b01 = n_c01;
    drive(1'b0, 1'b1, 2);
    drive(1'b0, 1'b0, 4);
    chk("glitch_pulses", 32'(n_c01 - b01), 32'd0);
    chk("glitch_cnt", 32'(coin_cnt), 32'd1);

    // both sensors high 5 edges: one reject pulse, then a clean coin
    brej = n_rej; b00 = n_c00; b01 = n_c01;
    coin_5 = 1'b1; coin_10 = 1'b1;
    step(1);
    chk("rej_first", 32'(reject), 32'h1);
    chk("rej_code", 32'(code), 32'h3);
    step(1);
    chk("rej_second", 32'(reject), 32'h0);
    step(3);
    drive(1'b0, 1'b0, 2);
    chk("rej_pulses", 32'(n_rej - brej), 32'd1);
    chk("rej_cnt", 32'(coin_cnt), 32'd1);
    chk("rej_no_code", 32'((n_c00 - b00) + (n_c01 - b01)), 32'd0);
    drive(1'b1, 1'b0, 5);
    drive(1'b0, 1'b0, 2);
    chk("after_rej_cnt", 32'(coin_cnt), 32'd2);

    // coin_5 qualified, then coin_10 (and both) during RELEASE: nothing more
    b00 = n_c00; b01 = n_c01; brej = n_rej;
    drive(1'b1, 1'b0, 4);
    drive(1'b0, 1'b1, 4);
    drive(1'b1, 1'b1, 2);
    drive(1'b0, 1'b1, 2);
    drive(1'b0, 1'b0, 2);
    chk("rel_c00", 32'(n_c00 - b00), 32'd1);
    chk("rel_c01", 32'(n_c01 - b01), 32'd0);
    chk("rel_rej", 32'(n_rej - brej), 32'd0);
    chk("rel_cnt", 32'(coin_cnt), 32'd3);

    // sensor swap mid-qualify: coin_10 needs a fresh IDLE edge (5 edges total)
    b01 = n_c01;
    drive(1'b1, 1'b0, 2);
    drive(1'b0, 1'b1, 4);
    chk("swap_short", 32'(n_c01 - b01), 32'd0);
    step(1);
    chk("swap_emit", 32'(code), 32'h1);
    drive(1'b0, 1'b0, 3);
    chk("swap_cnt", 32'(coin_cnt), 32'd4);

    // reset during QUAL (cnt=2), coin still present after release
    b00 = n_c00;
    drive(1'b1, 1'b0, 2);
    rst = 1'b0;
    #1;
    chk("qrst_code", 32'(code), 32'h3);
    chk("qrst_cnt", 32'(coin_cnt), 32'h0);
    step(2);
    rst = 1'b1;
    step(3);
    chk("qrst_wait", 32'(code), 32'h3);
    step(1);
    chk("qrst_accept", 32'(code), 32'h0);
    drive(1'b0, 1'b0, 3);
    chk("qrst_cnt_after", 32'(coin_cnt), 32'd1);
    chk("qrst_pulses", 32'(n_c00 - b00), 32'd1);

    // 256 coin_10 insertions: every one coded, count saturates
    b01 = n_c01;
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, DEB);
      drive(1'b0, 1'b0, 2);
    end
    chk("sat_pulses", 32'(n_c01 - b01), 32'd256);
    chk("sat_cnt", 32'(coin_cnt), 32'hFF);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
